// File: rtl/clock_monitor_pkg.sv
// Shared state encoding and default constants for the clock monitor.
// Top and sub-module import this so parameter defaults stay in one place.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_MEAS  = 2'd2
    } state_e;

    localparam int unsigned DEF_CNT_WIDTH   = 8;
    localparam int unsigned DEF_EXP_HALF    = 4;
    localparam int unsigned DEF_TOL         = 1;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_LOCK_COUNT  = 4;
    localparam int unsigned DEF_TIMEOUT     = 32;

endpackage

// File: rtl/clock_monitor_sync_edge_det.sv
// Multi-flop synchronizer followed by a registered rise/fall detector.
// Edges are suppressed until the pipeline has refilled after reset.
module sync_edge_det
    import clock_monitor_pkg::*;
#(
    parameter int unsigned C_SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [C_SYNC_STAGES-1:0] sync_q;
    logic [C_SYNC_STAGES:0]   prime_q;
    logic                     level_q;
    logic                     rise_q;
    logic                     fall_q;

    // prime_q keeps a reset-filled chain from looking like a real edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prime_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[C_SYNC_STAGES-2:0], async_i};
            prime_q <= {prime_q[C_SYNC_STAGES-1:0], 1'b1};
            level_q <= sync_q[C_SYNC_STAGES-1];
            rise_q  <= prime_q[C_SYNC_STAGES] &  sync_q[C_SYNC_STAGES-1] & ~level_q;
            fall_q  <= prime_q[C_SYNC_STAGES] & ~sync_q[C_SYNC_STAGES-1] &  level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures high/low/period of an asynchronous clock in clk cycles, checks each
// half against an expected value, tracks lock and flags a stopped clock.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int unsigned C_CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int unsigned C_EXP_HALF    = DEF_EXP_HALF,
    parameter int unsigned C_TOL         = DEF_TOL,
    parameter int unsigned C_SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned C_LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int unsigned C_TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear_err,
    input  logic                   clk_mon_in,
    output logic                   period_valid,
    output logic [C_CNT_WIDTH-1:0] high_out,
    output logic [C_CNT_WIDTH-1:0] low_out,
    output logic [C_CNT_WIDTH:0]   period_out,
    output logic                   locked,
    output logic                   err_period,
    output logic                   err_stopped,
    output logic [7:0]             err_count
);

    localparam int unsigned LOCK_W = $clog2(C_LOCK_COUNT + 1);
    localparam int unsigned TO_W   = $clog2(C_TIMEOUT + 1);

    logic                   level, rise, fall;
    state_e                 state_q;
    logic [C_CNT_WIDTH-1:0] hi_cnt_q, lo_cnt_q;
    logic [LOCK_W-1:0]      good_cnt_q, good_sat;
    logic [TO_W-1:0]        idle_cnt_q, idle_inc;
    logic                   stopped_q;
    logic                   period_valid_q, locked_q;
    logic [C_CNT_WIDTH-1:0] high_q, low_q;
    logic [C_CNT_WIDTH:0]   period_q;
    logic                   err_period_q, err_period_d;
    logic                   err_stopped_q, err_stopped_d;
    logic [7:0]             err_count_q, err_count_d, err_base;
    logic                   edge_seen, timeout_hit, meas_bad, err_event;

    sync_edge_det #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (clk_mon_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Widened unsigned distance; a saturated counter can never be in tolerance
    function automatic logic half_ok(input logic [C_CNT_WIDTH-1:0] cnt);
        logic [C_CNT_WIDTH:0] w, e, diff;
        w    = {1'b0, cnt};
        e    = (C_CNT_WIDTH+1)'(C_EXP_HALF);
        diff = (w >= e) ? (w - e) : (e - w);
        return (diff <= (C_CNT_WIDTH+1)'(C_TOL)) && (cnt != '1);
    endfunction

    always_comb begin
        edge_seen   = rise | fall;
        idle_inc    = idle_cnt_q + TO_W'(1);
        good_sat    = (good_cnt_q == LOCK_W'(C_LOCK_COUNT)) ? good_cnt_q : good_cnt_q + LOCK_W'(1);
        timeout_hit = enable && (state_q != S_IDLE) && !stopped_q && !edge_seen
                      && (idle_inc == TO_W'(C_TIMEOUT));
        meas_bad    = enable && (state_q == S_MEAS) && rise
                      && !(half_ok(hi_cnt_q) && half_ok(lo_cnt_q));
        err_event   = timeout_hit | meas_bad;
        err_base    = clear_err ? 8'd0 : err_count_q;
        err_count_d = (err_event && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
        err_period_d  = meas_bad    | (err_period_q  & ~clear_err);
        err_stopped_d = timeout_hit | (err_stopped_q & ~clear_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            hi_cnt_q       <= '0;
            lo_cnt_q       <= '0;
            good_cnt_q     <= '0;
            idle_cnt_q     <= '0;
            stopped_q      <= 1'b0;
            period_valid_q <= 1'b0;
            high_q         <= '0;
            low_q          <= '0;
            period_q       <= '0;
            locked_q       <= 1'b0;
            err_period_q   <= 1'b0;
            err_stopped_q  <= 1'b0;
            err_count_q    <= '0;
        end else begin
            period_valid_q <= 1'b0;
            err_period_q   <= err_period_d;
            err_stopped_q  <= err_stopped_d;
            err_count_q    <= err_count_d;
            if (!enable) begin
                state_q    <= S_IDLE;
                locked_q   <= 1'b0;
                good_cnt_q <= '0;
                hi_cnt_q   <= '0;
                lo_cnt_q   <= '0;
                idle_cnt_q <= '0;
                stopped_q  <= 1'b0;
            end else begin
                // Quiet-time watchdog; one timeout per quiet spell
                if (edge_seen) begin
                    idle_cnt_q <= '0;
                    stopped_q  <= 1'b0;
                end else if (timeout_hit) begin
                    idle_cnt_q <= '0;
                    stopped_q  <= 1'b1;
                end else if (!stopped_q && state_q != S_IDLE) begin
                    idle_cnt_q <= idle_inc;
                end
                case (state_q)
                    S_IDLE: state_q <= S_ALIGN;
                    S_ALIGN: begin
                        if (timeout_hit) begin
                            locked_q   <= 1'b0;
                            good_cnt_q <= '0;
                        end else if (rise) begin
                            state_q  <= S_MEAS;
                            hi_cnt_q <= C_CNT_WIDTH'(1);
                            lo_cnt_q <= '0;
                        end
                    end
                    S_MEAS: begin
                        if (timeout_hit) begin
                            state_q    <= S_ALIGN;
                            locked_q   <= 1'b0;
                            good_cnt_q <= '0;
                            hi_cnt_q   <= '0;
                            lo_cnt_q   <= '0;
                        end else if (rise) begin
                            period_valid_q <= 1'b1;
                            high_q         <= hi_cnt_q;
                            low_q          <= lo_cnt_q;
                            period_q       <= {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
                            hi_cnt_q       <= C_CNT_WIDTH'(1);
                            lo_cnt_q       <= '0;
                            if (meas_bad) begin
                                good_cnt_q <= '0;
                                locked_q   <= 1'b0;
                            end else begin
                                good_cnt_q <= good_sat;
                                locked_q   <= (good_sat == LOCK_W'(C_LOCK_COUNT));
                            end
                        end else if (level) begin
                            if (hi_cnt_q != '1) hi_cnt_q <= hi_cnt_q + C_CNT_WIDTH'(1);
                        end else begin
                            if (lo_cnt_q != '1) lo_cnt_q <= lo_cnt_q + C_CNT_WIDTH'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign period_valid = period_valid_q;
    assign high_out     = high_q;
    assign low_out      = low_q;
    assign period_out   = period_q;
    assign locked       = locked_q;
    assign err_period   = err_period_q;
    assign err_stopped  = err_stopped_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: hand-written period table checked on
// every period_valid, plus timed checks for timeout, clear, reset and enable.
module tb_clock_monitor;

    logic       clk = 1'b0;
    logic       rst, enable, clear_err, clk_mon_in;
    logic       period_valid, locked, err_period, err_stopped;
    logic [7:0] high_out, low_out, err_count;
    logic [8:0] period_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int h;
        int l;
        int lk;
        int ep;
        int ec;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    clock_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear_err    (clear_err),
        .clk_mon_in   (clk_mon_in),
        .period_valid (period_valid),
        .high_out     (high_out),
        .low_out      (low_out),
        .period_out   (period_out),
        .locked       (locked),
        .err_period   (err_period),
        .err_stopped  (err_stopped),
        .err_count    (err_count)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pv"},   int'(period_valid), 0);
        chk({tag, "_hi"},   int'(high_out),     0);
        chk({tag, "_lo"},   int'(low_out),      0);
        chk({tag, "_per"},  int'(period_out),   0);
        chk({tag, "_lock"}, int'(locked),       0);
        chk({tag, "_errp"}, int'(err_period),   0);
        chk({tag, "_errs"}, int'(err_stopped),  0);
        chk({tag, "_ecnt"}, int'(err_count),    0);
    endtask

    // Drive one high/low pair and record what its measurement must show
    task automatic pair(input int h, input int l, input int lk, input int ep, input int ec);
        exp_q.push_back('{h, l, lk, ep, ec});
        clk_mon_in = 1'b1;
        repeat (h) @(negedge clk);
        clk_mon_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic hold(input logic lvl, input int n);
        clk_mon_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (period_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pv", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pv_high",   int'(high_out),   e.h);
                chk("pv_low",    int'(low_out),    e.l);
                chk("pv_period", int'(period_out), e.h + e.l);
                chk("pv_locked", int'(locked),     e.lk);
                chk("pv_errp",   int'(err_period), e.ep);
                chk("pv_ecnt",   int'(err_count),  e.ec);
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; clear_err = 1'b0; clk_mon_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("post_rst");

        // Nominal 4/4 clock locks on the 4th measured period
        enable = 1'b1;
        hold(1'b0, 5);
        repeat (3) pair(4, 4, 0, 0, 0);
        repeat (2) pair(4, 4, 1, 0, 0);
        // One long high phase breaks lock, then 3/5 relocks after 4
        pair(6, 4, 0, 1, 1);
        repeat (3) pair(3, 5, 0, 1, 1);
        pair(3, 5, 1, 1, 1);

        // Stop the clock low: flag appears 32 cycles after the fall pulse
        hold(1'b1, 3);
        clk_mon_in = 1'b0;
        repeat (35) @(negedge clk);
        chk("stop_early", int'(err_stopped), 0);
        chk("stop_lock_before", int'(locked), 1);
        @(negedge clk);
        chk("stop_flag", int'(err_stopped), 1);
        chk("stop_lock", int'(locked), 0);
        chk("stop_ecnt", int'(err_count), 2);
        repeat (40) @(negedge clk);
        chk("stop_once_ecnt", int'(err_count), 2);
        chk("stop_held", int'(err_stopped), 1);

        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("clr_errp", int'(err_period), 0);
        chk("clr_errs", int'(err_stopped), 0);
        chk("clr_ecnt", int'(err_count), 0);
        chk("clr_keeps_high", int'(high_out), 3);

        // Clear coincident with a fresh timeout: the new error wins
        clk_mon_in = 1'b1;
        repeat (35) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("clr_to_errs", int'(err_stopped), 1);
        chk("clr_to_ecnt", int'(err_count), 1);
        chk("clr_to_errp", int'(err_period), 0);

        // Restart after stop: first rise only aligns
        hold(1'b0, 4);
        repeat (2) pair(4, 4, 0, 0, 1);

        // Reset in the middle of a high phase
        clk_mon_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 3);
        hold(1'b0, 4);
        repeat (3) pair(4, 4, 0, 0, 0);
        pair(4, 4, 1, 0, 0);

        // Drop enable in a low phase: only lock clears
        hold(1'b1, 4);
        hold(1'b0, 2);
        chk("pre_drop_lock", int'(locked), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_lock", int'(locked), 0);
        chk("drop_high_held", int'(high_out), 4);
        chk("drop_period_held", int'(period_out), 8);
        chk("drop_ecnt", int'(err_count), 0);
        enable = 1'b1;
        @(negedge clk);
        repeat (2) pair(4, 4, 0, 0, 0);
        hold(1'b1, 8);
        chk("pending_periods", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
